victim_cache_control: RTL and testbench

Controller and scheduler for the 4-entry, 256-bit-line victim array. It keeps per-entry tag, valid and dirty state and true-LRU ages, and serves two kinds of L1 request. Lookup: on an L1 miss, hit data is returned and the entry is handed back to L1, because the victim cache is exclusive. Evict: L1 pushes out a line; if the chosen slot holds a dirty line, that line is first written back to L2. The block sits between the L1 cache controller, the victim array and the L2/physical-memory port.

---
 rtl/victim_cache_control_if.sv | 38 +++
 rtl/victim_cache_control.sv | 204 ++++++++++++++++++++
 tb/tb_victim_cache_control.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/victim_cache_control_if.sv
// L1 request/response, victim array and L2 writeback signals of the victim cache controller.
interface victim_cache_control_if #(
    parameter int unsigned TAG_W  = 11,
    parameter int unsigned LINE_W = 256
);
    logic              lookup_req;
    logic [TAG_W-1:0]  lookup_tag;
    logic              evict_req;
    logic [TAG_W-1:0]  evict_tag;
    logic              evict_dirty;
    logic [LINE_W-1:0] evict_data;
    logic              resp;
    logic              hit;
    logic [LINE_W-1:0] hit_data;
    logic              hit_dirty;
    logic              vic_load;
    logic [1:0]        vic_index;
    logic [LINE_W-1:0] vic_wdata;
    logic [LINE_W-1:0] vic_rdata;
    logic              mem_write;
    logic [15:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp;

    modport slave (
        input  lookup_req, lookup_tag, evict_req, evict_tag, evict_dirty, evict_data,
               vic_rdata, mem_resp,
        output resp, hit, hit_data, hit_dirty, vic_load, vic_index, vic_wdata,
               mem_write, mem_addr, mem_wdata
    );

    modport master (
        output lookup_req, lookup_tag, evict_req, evict_tag, evict_dirty, evict_data,
               vic_rdata, mem_resp,
        input  resp, hit, hit_data, hit_dirty, vic_load, vic_index, vic_wdata,
               mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/victim_cache_control.sv
// Controller for a 4-entry exclusive victim cache with true-LRU replacement and dirty writeback.
// Optional macro VICTIM_PERF_EN adds saturating hit/miss/writeback counters.
module victim_cache_control #(
    parameter int unsigned TAG_W  = 11,
    parameter int unsigned LINE_W = 256
) (
    input  logic clk,
    input  logic rst,
    victim_cache_control_if.slave bus
`ifdef VICTIM_PERF_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
    output logic [15:0] wb_count
`endif
);
    localparam int unsigned WAYS  = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, INSERT} state_t;

    state_t                        state_q, state_d;
    logic [WAYS-1:0][TAG_W-1:0]    tag_q;
    logic [WAYS-1:0]               valid_q;
    logic [WAYS-1:0]               dirty_q;
    logic [WAYS-1:0][IDX_W-1:0]    age_q;
    logic [TAG_W-1:0]              req_tag_q;
    logic                          req_dirty_q;
    logic [LINE_W-1:0]             req_data_q;
    logic [IDX_W-1:0]              way_q;

    logic                          lk_hit;
    logic [IDX_W-1:0]              lk_way;
    logic                          ev_match;
    logic [IDX_W-1:0]              ev_match_way;
    logic                          inv_found;
    logic [IDX_W-1:0]              inv_way;
    logic [IDX_W-1:0]              lru_way;
    logic [IDX_W-1:0]              sel_way;
    logic                          sel_wb;

    // Lookup match against the latched tag; lowest matching way wins
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == req_tag_q) begin
                lk_hit = 1'b1;
                lk_way = IDX_W'(i);
            end
        end
    end

    // Eviction slot choice: tag reuse, then lowest invalid way, then LRU
    always_comb begin
        ev_match     = 1'b0;
        ev_match_way = '0;
        inv_found    = 1'b0;
        inv_way      = '0;
        lru_way      = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == bus.evict_tag) begin
                ev_match     = 1'b1;
                ev_match_way = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_way   = IDX_W'(i);
            end
            if (age_q[i] == IDX_W'(WAYS - 1)) begin
                lru_way = IDX_W'(i);
            end
        end
        sel_way = ev_match ? ev_match_way : (inv_found ? inv_way : lru_way);
        sel_wb  = !ev_match && valid_q[sel_way] && dirty_q[sel_way];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs; array read data is combinational on vic_index
    always_comb begin
        state_d       = state_q;
        bus.resp      = 1'b0;
        bus.hit       = 1'b0;
        bus.hit_data  = '0;
        bus.hit_dirty = 1'b0;
        bus.vic_load  = 1'b0;
        bus.vic_index = '0;
        bus.vic_wdata = '0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.evict_req) begin
                    state_d = sel_wb ? WRITEBACK : INSERT;
                end else if (bus.lookup_req) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                bus.vic_index = lk_way;
                bus.resp      = 1'b1;
                bus.hit       = lk_hit;
                bus.hit_data  = bus.vic_rdata;
                bus.hit_dirty = lk_hit && dirty_q[lk_way];
                state_d       = IDLE;
            end
            WRITEBACK: begin
                bus.vic_index = way_q;
                bus.mem_write = 1'b1;
                bus.mem_addr  = 16'({tag_q[way_q], 5'b0});
                bus.mem_wdata = bus.vic_rdata;
                if (bus.mem_resp) begin
                    state_d = INSERT;
                end
            end
            INSERT: begin
                bus.vic_load  = 1'b1;
                bus.vic_index = way_q;
                bus.vic_wdata = req_data_q;
                bus.resp      = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-way bookkeeping and request latches
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            req_tag_q   <= '0;
            req_dirty_q <= 1'b0;
            way_q       <= '0;
            for (int i = 0; i < int'(WAYS); i++) begin
                age_q[i] <= IDX_W'(i);
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.evict_req) begin
                        req_tag_q   <= bus.evict_tag;
                        req_dirty_q <= bus.evict_dirty;
                        way_q       <= sel_way;
                    end else if (bus.lookup_req) begin
                        req_tag_q <= bus.lookup_tag;
                    end
                end
                LOOKUP: begin
                    if (lk_hit) begin
                        valid_q[lk_way] <= 1'b0;
                    end
                end
                INSERT: begin
                    tag_q[way_q]   <= req_tag_q;
                    valid_q[way_q] <= 1'b1;
                    dirty_q[way_q] <= req_dirty_q;
                    for (int i = 0; i < int'(WAYS); i++) begin
                        if (age_q[i] < age_q[way_q]) begin
                            age_q[i] <= age_q[i] + IDX_W'(1);
                        end
                    end
                    age_q[way_q] <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.evict_req) begin
            req_data_q <= bus.evict_data;
        end
    end

`ifdef VICTIM_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state_q == LOOKUP && lk_hit && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (state_q == LOOKUP && !lk_hit && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
            if (state_q == WRITEBACK && bus.mem_resp && wb_count != 16'hFFFF) begin
                wb_count <= wb_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_victim_cache_control.sv
// Directed and randomized bench for victim_cache_control against a recency-queue cache model.
module tb_victim_cache_control;
    localparam int unsigned TAG_W  = 11;
    localparam int unsigned LINE_W = 256;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    victim_cache_control_if #(.TAG_W(TAG_W), .LINE_W(LINE_W)) ifc ();

`ifdef VICTIM_PERF_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic [15:0] wb_count;
`endif

    victim_cache_control #(.TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
`ifdef VICTIM_PERF_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count),
        .wb_count(wb_count)
`endif
    );

    // Victim data array: synchronous write, combinational read
    logic [LINE_W-1:0] varray [4];
    always @(posedge clk) begin
        if (ifc.vic_load) varray[ifc.vic_index] <= ifc.vic_wdata;
    end
    assign ifc.vic_rdata = varray[ifc.vic_index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-way contents plus recency order (front = most recent)
    logic              m_valid [4];
    logic              m_dirty [4];
    logic [TAG_W-1:0]  m_tag   [4];
    logic [LINE_W-1:0] m_data  [4];
    int                lru_q[$];
    int                m_hits, m_miss, m_wb;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        lru_q = {0, 1, 2, 3};
        m_hits = 0;
        m_miss = 0;
        m_wb   = 0;
    endfunction

    function automatic void touch(input int w);
        for (int i = 0; i < lru_q.size(); i++) begin
            if (lru_q[i] == w) begin
                lru_q.delete(i);
                break;
            end
        end
        lru_q.push_front(w);
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_lookup(input logic [TAG_W-1:0] t);
        int w;
        w = -1;
        for (int i = 0; i < 4; i++) if (w < 0 && m_valid[i] && m_tag[i] == t) w = i;
        ifc.lookup_req = 1'b1;
        ifc.lookup_tag = t;
        @(posedge clk); #1;
        check("lk_resp", ifc.resp, 1);
        check("lk_hit", ifc.hit, w >= 0);
        check("lk_vic_load", ifc.vic_load, 0);
        check("lk_mem_write", ifc.mem_write, 0);
        if (w >= 0) begin
            check("lk_hit_data", ifc.hit_data, m_data[w]);
            check("lk_hit_dirty", ifc.hit_dirty, m_dirty[w]);
            m_valid[w] = 1'b0;
            m_hits++;
        end else begin
            m_miss++;
        end
        ifc.lookup_req = 1'b0;
        @(posedge clk); #1;
        check("lk_idle_resp", ifc.resp, 0);
    endtask

    task automatic do_evict(input logic [TAG_W-1:0] t, input logic d,
                            input logic [LINE_W-1:0] data, input int wb_wait);
        int   w;
        logic match;
        logic wb;
        w = -1;
        match = 1'b0;
        for (int i = 0; i < 4; i++) if (w < 0 && m_valid[i] && m_tag[i] == t) begin
            w = i;
            match = 1'b1;
        end
        if (w < 0) for (int i = 0; i < 4; i++) if (w < 0 && !m_valid[i]) w = i;
        if (w < 0) w = lru_q[$];
        wb = !match && m_valid[w] && m_dirty[w];
        ifc.evict_req   = 1'b1;
        ifc.evict_tag   = t;
        ifc.evict_dirty = d;
        ifc.evict_data  = data;
        @(posedge clk); #1;
        if (wb) begin
            check("wb_mem_write", ifc.mem_write, 1);
            check("wb_mem_addr", ifc.mem_addr, {m_tag[w], 5'b0});
            check("wb_mem_wdata", ifc.mem_wdata, m_data[w]);
            check("wb_resp", ifc.resp, 0);
            repeat (wb_wait) begin
                @(posedge clk); #1;
                check("wb_hold", {ifc.mem_write, ifc.resp, ifc.mem_addr}, {1'b1, 1'b0, m_tag[w], 5'b0});
            end
            ifc.mem_resp = 1'b1;
            @(posedge clk); #1;
            ifc.mem_resp = 1'b0;
            m_wb++;
        end
        check("ins_mem_write", ifc.mem_write, 0);
        check("ins_resp", ifc.resp, 1);
        check("ins_hit", ifc.hit, 0);
        check("ins_vic_load", ifc.vic_load, 1);
        check("ins_vic_index", ifc.vic_index, w);
        check("ins_vic_wdata", ifc.vic_wdata, data);
        ifc.evict_req = 1'b0;
        m_valid[w] = 1'b1;
        m_dirty[w] = d;
        m_tag[w]   = t;
        m_data[w]  = data;
        touch(w);
        @(posedge clk); #1;
        check("ev_idle_resp", ifc.resp, 0);
        check("ev_idle_load", ifc.vic_load, 0);
    endtask

    task automatic fill_dirty();
        for (int i = 0; i < 4; i++) do_evict(TAG_W'(16 + i), 1'b1, rand_line(), 0);
    endtask

    initial begin
        logic [LINE_W-1:0] pat;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ifc.lookup_req  = 1'b0;
        ifc.lookup_tag  = '0;
        ifc.evict_req   = 1'b0;
        ifc.evict_tag   = '0;
        ifc.evict_dirty = 1'b0;
        ifc.evict_data  = '0;
        ifc.mem_resp    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp", ifc.resp, 0);
        check("rst_outs", {ifc.vic_load, ifc.mem_write, ifc.hit, ifc.vic_index, ifc.mem_addr}, 0);
        rst = 1'b0;

        do_lookup(11'h123);

        pat = rand_line();
        do_evict(11'h0A1, 1'b0, pat, 0);
        do_lookup(11'h0A1);
        do_lookup(11'h0A1);

        do_reset();
        fill_dirty();
        do_evict(11'h020, 1'b0, rand_line(), 5);

        do_reset();
        fill_dirty();
        do_lookup(11'h011);
        do_evict(11'h030, 1'b1, rand_line(), 0);
        check("inv_pref_way", ifc.vic_index, 0);

        // Simultaneous requests: evict first, held lookup sees the new line
        ifc.lookup_req = 1'b1;
        ifc.lookup_tag = 11'h055;
        do_evict(11'h055, 1'b1, rand_line(), 2);
        do_lookup(11'h055);

        // Reset in the middle of a writeback
        do_reset();
        fill_dirty();
        ifc.evict_req   = 1'b1;
        ifc.evict_tag   = 11'h020;
        ifc.evict_dirty = 1'b0;
        ifc.evict_data  = rand_line();
        @(posedge clk); #1;
        check("rwb_mem_write", ifc.mem_write, 1);
        ifc.evict_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rwb_drop", {ifc.mem_write, ifc.resp, ifc.mem_addr}, 0);
        rst = 1'b0;
        model_reset();
        do_lookup(11'h010);
        do_lookup(11'h013);

        for (int n = 0; n < 150; n++) begin
            logic [TAG_W-1:0] t;
            t = TAG_W'(16 + $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) do_lookup(t);
            else do_evict(t, 1'($urandom_range(0, 1)), rand_line(), int'($urandom_range(0, 3)));
        end

`ifdef VICTIM_PERF_EN
        check("perf_hit", hit_count, m_hits);
        check("perf_miss", miss_count, m_miss);
        check("perf_wb", wb_count, m_wb);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
